alu8: RTL and testbench
=======================

Name: alu8

Overview:
- Registered 8-bit arithmetic/logic unit for the MGT2_8R processor datapath.
- Takes two operands and a 3-bit opcode.
- Produces result plus zero/carry/overflow status flags, registered one clock after the operands are accepted.
- Feeds the register-file writeback and the condition-flag register.

Parameters:
- WIDTH, 8, operand/result width in bits; all flag rules below are stated for the general WIDTH, with examples at 8.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op_code  input  3  operation select
- out_valid  output  1  result/flags updated from an accepted operation
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- carry  output  1  carry/borrow/shift-out flag
- overflow  output  1  two's-complement signed overflow flag

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, result=0, zero=1, carry=0, overflow=0, out_valid=0. rst has priority over in_valid.
- Latency: exactly 1 cycle. A rising edge with in_valid=1 and rst=0 registers all outputs from that cycle's a, b and op_code, and sets out_valid=1.
- Idle: an edge with in_valid=0 sets out_valid=0. result and the flags hold their previous values.
- No backpressure; a new operation is accepted every cycle.
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT a (b ignored).
  - 110 SHL: a<<1, zero fill.
  - 111 SHR: a>>1, logical, zero fill.
- Width/wrap: result is the low WIDTH bits; arithmetic wraps modulo 2^WIDTH.
- carry:
  - ADD: unsigned carry-out, bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: borrow, 1 iff a < b unsigned.
  - SHL: a[WIDTH-1].
  - SHR: a[0].
  - Logic ops: 0.
- overflow:
  - ADD: 1 iff a and b have the same sign and the result sign differs.
  - SUB: 1 iff a and b have different signs and the result sign differs from a.
  - All other ops: 0.
- zero: 1 iff the registered result is all zeros, for every opcode.
- Flags are registered together with result; out_valid, result and all flags always describe the same operation.

Decomposition:
- Shared package alu_pkg holds:
  - opcode typedef/localparams OP_ADD..OP_SHR (values above)
  - WIDTH default constant
- One natural sub-module: alu_addsub, a combinational WIDTH-bit adder/subtractor.
  - Computes a + (b XOR {WIDTH{sub}}) + sub.
  - Outputs sum, carry and overflow; borrow = NOT raw carry-out when sub=1.
- The top level holds the logic/shift mux, zero detect and output registers.

Test Plan:
- ADD, in_valid=1: 1+2 -> next cycle result=3, z=0, c=0, v=0, out_valid=1. 255+1 -> 0x00, z=1, c=1, v=0.
- ADD signed: 127+1 -> 0x80, c=0, v=1. 192+192 -> 0x80, c=1, v=0. 50+206 -> 0x00, z=1, c=1, v=0. 200+60 -> 0x04, c=1, v=0.
- SUB: 10-3 -> 7, c=0, v=0. 77-77 -> 0, z=1, c=0. 5-10 -> 0xFB, c=1, v=0. 0-255 -> 0x01, c=1, v=0.
- SUB signed: 128-1 -> 0x7F, c=0, v=1. 127-255 -> 0x80, c=1, v=1. 100-200 -> 0x9C, c=1, v=1. 200-100 -> 0x64, c=0, v=1.
- Logic/shift with a=0xA5, b=0x0F:
  - AND -> 0x05
  - OR -> 0xAF
  - XOR -> 0xAA
  - NOT -> 0x5A
  - SHL -> 0x4A, c=1
  - SHR -> 0x52, c=1
  - v=0 for all six.
- Control:
  - rst=1 mid-stream with in_valid=1 -> next edge result=0, z=1, c=0, v=0, out_valid=0.
  - in_valid=0 -> out_valid=0, previous result/flags held.
  - Back-to-back valid ops -> one result per cycle, in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encoding and default width.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

endpackage

// File: rtl/alu8_if.sv
// Operand/result bundle between the datapath issue stage (master) and the ALU (slave).
interface alu8_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op_code;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, op_code,
    input  out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, op_code,
    output out_valid, result, zero, carry, overflow
  );

endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor: a + (b ^ {WIDTH{sub}}) + sub.
// o_carry is the carry-out for add and the borrow (a < b unsigned) for subtract.
module alu_addsub #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = i_b ^ {WIDTH{i_sub}};
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];

  // Raw carry-out of a + ~b + 1 is 1 when no borrow occurred, so invert it for subtract.
  assign o_carry = w_full[WIDTH] ^ i_sub;

  // Signed overflow: both adder inputs share a sign and the sum's sign differs.
  // With the inverted b this covers subtract's "signs differ" rule as well.
  assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu8.sv
// Registered ALU: result and zero/carry/overflow flags appear one clock after
// an accepted operation; all outputs always describe the same operation.
module alu8
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  alu8_if.slave  bus
);

  logic [WIDTH-1:0] w_sum;
  logic             w_as_carry;
  logic             w_as_overflow;
  logic             w_sub;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;
  op_e              w_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;

  assign w_op  = op_e'(bus.op_code);
  assign w_sub = (w_op == OP_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a        (bus.a),
    .i_b        (bus.b),
    .i_sub      (w_sub),
    .o_sum      (w_sum),
    .o_carry    (w_as_carry),
    .o_overflow (w_as_overflow)
  );

  // Select the result and flags of the current opcode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_result   = w_sum;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    unique case (w_op)
      OP_ADD, OP_SUB: begin
        w_result   = w_sum;
        w_carry    = w_as_carry;
        w_overflow = w_as_overflow;
      end
      OP_AND: w_result = bus.a & bus.b;
      OP_OR:  w_result = bus.a | bus.b;
      OP_XOR: w_result = bus.a ^ bus.b;
      OP_NOT: w_result = ~bus.a;
      OP_SHL: begin
        w_result = {bus.a[WIDTH-2:0], 1'b0};
        w_carry  = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        w_result = {1'b0, bus.a[WIDTH-1:1]};
        w_carry  = bus.a[0];
      end
      default: ;
    endcase
  end

  // Output registers: reset wins, accepted ops load everything, idle holds data.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (bus.in_valid) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_zero      <= (w_result == '0);
      r_carry     <= w_carry;
      r_overflow  <= w_overflow;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed table, control sequences, random vs. model.
module tb_alu8;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu8_if #(.WIDTH(W)) bus ();

  alu8 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural reference computed with plain integer arithmetic.
  function automatic int sval(logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  function automatic exp_t model(op_e op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    int   s;
    int   sv;
    e.c = 1'b0;
    e.v = 1'b0;
    e.res = '0;
    case (op)
      OP_ADD: begin
        s = int'(a) + int'(b);
        sv = sval(a) + sval(b);
        e.res = W'(s);
        e.c = (s >= (1 << W));
        e.v = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
      end
      OP_SUB: begin
        s = int'(a) - int'(b);
        sv = sval(a) - sval(b);
        e.res = W'(s);
        e.c = (int'(a) < int'(b));
        e.v = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
      end
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_NOT: e.res = W'(((1 << W) - 1) - int'(a));
      OP_SHL: begin
        e.res = W'(int'(a) * 2);
        e.c = (int'(a) >= (1 << (W-1)));
      end
      OP_SHR: begin
        e.res = W'(int'(a) / 2);
        e.c = (int'(a) % 2) == 1;
      end
      default: ;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic check(string name, logic exp_ov, logic [W-1:0] exp_res,
                       logic exp_z, logic exp_c, logic exp_v);
    n_vec++;
    if ({bus.out_valid, bus.result, bus.zero, bus.carry, bus.overflow} !==
        {exp_ov, exp_res, exp_z, exp_c, exp_v}) begin
      n_err++;
      $display("FAIL %s: got ov=%b res=%h z=%b c=%b v=%b, expected ov=%b res=%h z=%b c=%b v=%b",
               name, bus.out_valid, bus.result, bus.zero, bus.carry, bus.overflow,
               exp_ov, exp_res, exp_z, exp_c, exp_v);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then step past the rising edge.
  task automatic drive(logic valid, op_e op, logic [W-1:0] a, logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = valid;
    bus.op_code  = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];
  exp_t held;
  exp_t e;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_code  = OP_ADD;
    bus.a        = 8'h12;
    bus.b        = 8'h34;

    vecs[0]  = '{OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{OP_ADD, 8'hC0, 8'hC0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{OP_ADD, 8'h32, 8'hCE, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{OP_ADD, 8'hC8, 8'h3C, 8'h04, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_SUB, 8'h0A, 8'h03, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_SUB, 8'h4D, 8'h4D, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{OP_SUB, 8'h05, 8'h0A, 8'hFB, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{OP_SUB, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_SUB, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{OP_SUB, 8'h64, 8'hC8, 8'h9C, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{OP_SUB, 8'hC8, 8'h64, 8'h64, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{OP_AND, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{OP_OR,  8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{OP_XOR, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{OP_NOT, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{OP_SHL, 8'hA5, 8'h0F, 8'h4A, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{OP_SHR, 8'hA5, 8'h0F, 8'h52, 1'b0, 1'b1, 1'b0};

    // Reset with in_valid high: reset must win.
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, applied back-to-back (in_valid stays high).
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_%s", i, vecs[i].op.name()), 1'b1,
            vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v);
    end

    // Idle cycles hold result/flags from the last SHR (0x52, c=1).
    drive(1'b0, OP_ADD, 8'hFF, 8'h01);
    check("idle1", 1'b0, 8'h52, 1'b0, 1'b1, 1'b0);
    drive(1'b0, OP_SUB, 8'h00, 8'h00);
    check("idle2", 1'b0, 8'h52, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset with a valid op present.
    drive(1'b1, OP_SUB, 8'h80, 8'h01);
    check("pre_rst", 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_code  = OP_ADD;
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    @(posedge clk);
    #1;
    check("mid_rst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // First op after reset.
    drive(1'b1, OP_ADD, 8'h01, 8'h02);
    check("post_rst", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    held = '{8'h03, 1'b0, 1'b0, 1'b0};

    // Random mix of valid and idle cycles against the model.
    for (int i = 0; i < 400; i++) begin
      logic         valid;
      op_e          op;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      valid = ($urandom_range(0, 3) != 0);
      op    = op_e'($urandom_range(0, 7));
      ra    = W'($urandom);
      rb    = W'($urandom);
      if ((i % 16) == 0) ra = '0;
      if ((i % 16) == 1) rb = ra;
      drive(valid, op, ra, rb);
      if (valid) begin
        e = model(op, ra, rb);
        held = e;
      end
      check($sformatf("rand%0d", i), valid, held.res, held.z, held.c, held.v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
